// File: rtl/prog_loader_ram256x16.sv
// Writable 2**ADDR_W x 16 program memory filled from a high-byte-first byte stream.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte after each load.
module prog_loader_ram256x16 #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_last,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              chk_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [7:0]        hi_q;
  logic              hi_we, wr_en;
  logic [15:0]       mem_q [DEPTH];

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              chk_err_q, chk_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    rx_ready = 1'b0;
    busy     = 1'b0;
    hi_we    = 1'b0;
    wr_en    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          wptr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = 8'h00;
          chk_err_d = 1'b0;
`endif
        end
      end
      S_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          hi_we   = 1'b1;
          state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
        end
      end
      S_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          // A full memory ends the load even without rx_last.
          if (rx_last || (wptr_q == '1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_HI;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          chk_err_d = (8'(sum_q + rx_data) != 8'h00);
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= 8'h00;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (hi_we) hi_q <= rx_data;
    if (wr_en) mem_q[wptr_q] <= {hi_q, rx_data};
  end

  assign data     = mem_q[addr];
  assign done     = done_q;
  assign word_cnt = cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign chk_err  = chk_err_q;
`else
  assign chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader_ram256x16.sv
// Directed bench for prog_loader_ram256x16: table-driven load plus multi-cycle corner sequences.
module tb_prog_loader_ram256x16;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid, rx_last;
  logic [7:0]  rx_data;
  logic        rx_ready, busy, done, chk_err;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [8:0]  word_cnt;

  int tests = 0;
  int fails = 0;

  prog_loader_ram256x16 dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .addr(addr), .data(data), .busy(busy), .done(done),
    .word_cnt(word_cnt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        last;
    logic [15:0] word;
    logic [8:0]  cnt;
  } vec_t;

  vec_t vt[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_last  = l;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [7:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    chk(nm, data, exp);
  endtask

  task automatic finish_chk();
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] tog[6];
    vt[0] = '{8'h12, 8'h34, 1'b0, 16'h1234, 9'd1};
    vt[1] = '{8'h56, 8'h78, 1'b1, 16'h5678, 9'd2};
    tog[0] = 8'hA1; tog[1] = 8'hB2; tog[2] = 8'hC3;
    tog[3] = 8'hD4; tog[4] = 8'hE5; tog[5] = 8'hF6;

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_last = 1'b0;
    rx_data = 8'h00; addr = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_chk_err", chk_err, 0);
    reset = 1'b0;

    // Basic table-driven load
    pulse_start();
    chk("hi_ready", rx_ready, 1);
    chk("hi_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      send_byte(vt[i].hi, 1'b0);
      send_byte(vt[i].lo, vt[i].last);
      chk($sformatf("vec%0d_cnt", i), word_cnt, vt[i].cnt);
    end
    finish_chk();
    @(negedge clk);
    chk("vec_done", done, 1);
    chk("vec_busy", busy, 0);
    chk("vec_ready", rx_ready, 0);
    for (int i = 0; i < 2; i++) read_chk($sformatf("vec%0d_mem", i), 8'(i), vt[i].word);
`ifndef LOADER_CHECKSUM_EN
    chk("nochk_err", chk_err, 0);
`endif

    // rx_valid toggling every cycle
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rx_data = tog[k]; rx_valid = 1'b1; rx_last = (k == 5);
      chk($sformatf("tog%0d_ready", k), rx_ready, 1);
      @(negedge clk);
      rx_valid = 1'b0; rx_data = 8'hEE; rx_last = 1'b1;
      chk($sformatf("tog%0d_cnt", k), word_cnt, 9'((k + 1) / 2));
    end
    rx_last = 1'b0;
    finish_chk();
    @(negedge clk);
    chk("tog_done", done, 1);
    read_chk("tog_mem0", 8'd0, 16'hA1B2);
    read_chk("tog_mem1", 8'd1, 16'hC3D4);
    read_chk("tog_mem2", 8'd2, 16'hE5F6);

    // Full-memory load without rx_last
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_byte(b, 1'b0);
      send_byte(~b, 1'b0);
    end
    finish_chk();
    @(negedge clk);
    chk("full_cnt", word_cnt, 256);
    chk("full_done", done, 1);
    chk("full_ready", rx_ready, 0);
    read_chk("full_mem255", 8'd255, 16'hFF00);
    read_chk("full_mem128", 8'd128, 16'h807F);
    rx_data = 8'hAA; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_extra_ready", rx_ready, 0);
    rx_valid = 1'b0;
    chk("full_extra_cnt", word_cnt, 256);
    read_chk("full_mem0", 8'd0, 16'h00FF);

    // Reset after the high byte of word 2
    pulse_start();
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cnt", word_cnt, 0);
    chk("abort_ready", rx_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    read_chk("abort_mem0", 8'd0, 16'h1122);
    read_chk("abort_mem1", 8'd1, 16'h3344);
    read_chk("abort_mem2", 8'd2, 16'h02FD);
    pulse_start();
    send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b1);
    finish_chk();
    @(negedge clk);
    chk("reload_cnt", word_cnt, 1);
    read_chk("reload_mem0", 8'd0, 16'h6677);
    read_chk("reload_mem1", 8'd1, 16'h3344);

    // start in LO is ignored
    pulse_start();
    send_byte(8'h9A, 1'b0);
    pulse_start();
    chk("lo_start_busy", busy, 1);
    send_byte(8'hBC, 1'b0);
    chk("lo_start_cnt1", word_cnt, 1);
    send_byte(8'hDE, 1'b0); send_byte(8'hF0, 1'b1);
    finish_chk();
    @(negedge clk);
    chk("lo_start_cnt2", word_cnt, 2);
    chk("lo_start_done", done, 1);
    read_chk("lo_start_mem0", 8'd0, 16'h9ABC);
    read_chk("lo_start_mem1", 8'd1, 16'hDEF0);

    // start in DONE restarts; then same-address read during write
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_cnt", word_cnt, 0);
    chk("restart_busy", busy, 1);
    send_byte(8'h13, 1'b0);
    @(negedge clk);
    addr = 8'd0; rx_data = 8'h57; rx_valid = 1'b1; rx_last = 1'b1;
    #1;
    chk("raw_old", data, 16'h9ABC);
    @(posedge clk);
    #1;
    chk("raw_new", data, 16'h1357);
    rx_valid = 1'b0; rx_last = 1'b0;
    finish_chk();
    @(negedge clk);
    chk("raw_done", done, 1);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b1);
    @(negedge clk);
    chk("chk_state_ready", rx_ready, 1);
    chk("chk_state_busy", busy, 1);
    chk("chk_state_done", done, 0);
    send_byte(8'hFD, 1'b0);
    @(negedge clk);
    chk("chk_good_err", chk_err, 0);
    chk("chk_good_done", done, 1);
    chk("chk_good_cnt", word_cnt, 1);
    read_chk("chk_good_mem0", 8'd0, 16'h0102);
    pulse_start();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b1);
    send_byte(8'hFC, 1'b0);
    @(negedge clk);
    chk("chk_bad_err", chk_err, 1);
    chk("chk_bad_done", done, 1);
    read_chk("chk_bad_mem0", 8'd0, 16'h0102);
    read_chk("chk_bad_mem1", 8'd1, 16'hDEF0);
    pulse_start();
    chk("chk_clear_err", chk_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
